// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multi-cycle control unit for the RV32I teaching CPU.
// Each instruction is walked through IF -> ID -> EX -> (MEM) -> (WB).
// Every memory access waits on MIO_ready. Illegal opcodes, illegal ALU
// functions and stalled memory accesses drop the unit into a sticky TRAP
// state that only rst can leave.
module mcpu_ctrl #(
    parameter int unsigned MIO_TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] OPcode,
    input  logic [2:0] Fun3,
    input  logic       Fun7,
    input  logic       Zero,
    input  logic       MIO_ready,
    output logic       PCWrite,
    output logic [1:0] PCSrc,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemReq,
    output logic       MemRW,
    output logic       CPU_MIO,
    output logic [2:0] ImmSel,
    output logic [1:0] ALUSrc_A,
    output logic [1:0] ALUSrc_B,
    output logic [3:0] ALU_Control,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic [2:0] state,
    output logic       trap,
    output logic [1:0] trap_cause
);

    // FSM states; the encodings are visible on the state output.
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_IF   = 3'd1,
        S_ID   = 3'd2,
        S_EX   = 3'd3,
        S_MEM  = 3'd4,
        S_WB   = 3'd5,
        S_TRAP = 3'd7
    } state_t;

    // Instruction classes recognised from the opcode field.
    typedef enum logic [3:0] {
        C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
    } cls_t;

    // Opcode field values (IR[6:2]).
    localparam logic [4:0] OP_R     = 5'b01100;
    localparam logic [4:0] OP_I     = 5'b00100;
    localparam logic [4:0] OP_LW    = 5'b00000;
    localparam logic [4:0] OP_SW    = 5'b01000;
    localparam logic [4:0] OP_BR    = 5'b11000;
    localparam logic [4:0] OP_JAL   = 5'b11011;
    localparam logic [4:0] OP_JALR  = 5'b11001;
    localparam logic [4:0] OP_LUI   = 5'b01101;
    localparam logic [4:0] OP_AUIPC = 5'b00101;

    // ALU operation codes.
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // Immediate formats.
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Mux selections.
    localparam logic [1:0] A_PC    = 2'b00;
    localparam logic [1:0] A_RS1   = 2'b01;
    localparam logic [1:0] A_OLDPC = 2'b10;
    localparam logic [1:0] A_ZERO  = 2'b11;
    localparam logic [1:0] B_RS2   = 2'b00;
    localparam logic [1:0] B_IMM   = 2'b01;
    localparam logic [1:0] B_FOUR  = 2'b10;
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    // Trap causes.
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Watchdog sizing: the counter only has to hold 0 .. MIO_TIMEOUT-1,
    // because the trap is taken on the wait cycle that would reach the limit.
    localparam int unsigned WDW = (MIO_TIMEOUT > 1) ? $clog2(MIO_TIMEOUT) : 1;
    localparam bit WD_EN = (MIO_TIMEOUT != 0);
    localparam logic [WDW-1:0] WD_LAST = WDW'((MIO_TIMEOUT == 0) ? 0 : MIO_TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           trap_q;
    logic [1:0]     trap_cause_q;
    logic [1:0]     cause_d;

    cls_t       cls;
    logic [2:0] imm_id;
    logic [3:0] alu_fn;
    logic       fun3_ok;
    logic       id_illegal;
    logic       wait_cycle;
    logic       wd_expire;

    // Classify the instruction and pick the immediate format used in ID.
    always_comb begin
        cls    = C_BAD;
        imm_id = IMM_I;
        case (OPcode)
            OP_R:     cls = C_R;
            OP_I:     cls = C_I;
            OP_LW:    cls = C_LW;
            OP_SW:    begin cls = C_SW;    imm_id = IMM_S; end
            OP_BR:    begin cls = C_BR;    imm_id = IMM_B; end
            OP_JAL:   begin cls = C_JAL;   imm_id = IMM_J; end
            OP_JALR:  cls = C_JALR;
            OP_LUI:   begin cls = C_LUI;   imm_id = IMM_U; end
            OP_AUIPC: begin cls = C_AUIPC; imm_id = IMM_U; end
            default:  cls = C_BAD;
        endcase
    end

    // ALU function for R and I-ALU; Fun7 only selects SUB for R-type,
    // since in I-type it is just an immediate bit.
    always_comb begin
        alu_fn  = ALU_ADD;
        fun3_ok = 1'b1;
        case (Fun3)
            3'b000:  alu_fn = (cls == C_R && Fun7) ? ALU_SUB : ALU_ADD;
            3'b100:  alu_fn = ALU_XOR;
            3'b110:  alu_fn = ALU_OR;
            3'b111:  alu_fn = ALU_AND;
            3'b101:  alu_fn = ALU_SRL;
            3'b010:  alu_fn = ALU_SLT;
            default: fun3_ok = 1'b0;
        endcase
    end

    // An instruction is rejected in ID if its opcode is unknown, or if it
    // is an ALU instruction whose function the ALU cannot perform.
    assign id_illegal = (cls == C_BAD) || ((cls == C_R || cls == C_I) && !fun3_ok);

    // Watchdog fires on the wait cycle that would bring the count to the limit;
    // a ready on that same cycle wins because wait_cycle requires !MIO_ready.
    assign wait_cycle = WD_EN && (state_q == S_IF || state_q == S_MEM) && !MIO_ready;
    assign wd_expire  = wait_cycle && (wd_q == WD_LAST);

    // Next state and control outputs, decoded from the current state and IR fields.
    always_comb begin
        state_d     = state_q;
        cause_d     = 2'b00;
        PCWrite     = 1'b0;
        PCSrc       = PC_ALU;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemReq      = 1'b0;
        MemRW       = 1'b0;
        ImmSel      = IMM_I;
        ALUSrc_A    = A_PC;
        ALUSrc_B    = B_RS2;
        ALU_Control = ALU_AND;
        MemtoReg    = WB_ALUOUT;
        RegWrite    = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF: begin
                MemReq      = 1'b1;
                IorD        = 1'b0;
                ALUSrc_A    = A_PC;
                ALUSrc_B    = B_FOUR;
                ALU_Control = ALU_ADD;
                if (MIO_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    PCSrc   = PC_ALU;
                    state_d = S_ID;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_ID: begin
                // Branch/jump target goes into ALUOut for use in EX.
                ALUSrc_A    = A_OLDPC;
                ALUSrc_B    = B_IMM;
                ALU_Control = ALU_ADD;
                ImmSel      = imm_id;
                if (id_illegal) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                case (cls)
                    C_R: begin
                        ALUSrc_A    = A_RS1;
                        ALUSrc_B    = B_RS2;
                        ALU_Control = alu_fn;
                        state_d     = S_WB;
                    end
                    C_I: begin
                        ALUSrc_A    = A_RS1;
                        ALUSrc_B    = B_IMM;
                        ImmSel      = IMM_I;
                        ALU_Control = alu_fn;
                        state_d     = S_WB;
                    end
                    C_LW, C_SW: begin
                        ALUSrc_A    = A_RS1;
                        ALUSrc_B    = B_IMM;
                        ALU_Control = ALU_ADD;
                        ImmSel      = (cls == C_SW) ? IMM_S : IMM_I;
                        state_d     = S_MEM;
                    end
                    C_BR: begin
                        // BEQ takes on Zero, BNE (Fun3[0]=1) on !Zero.
                        ALUSrc_A    = A_RS1;
                        ALUSrc_B    = B_RS2;
                        ALU_Control = ALU_SUB;
                        PCSrc       = PC_ALUOUT;
                        PCWrite     = Zero ^ Fun3[0];
                        state_d     = S_IF;
                    end
                    C_JAL: begin
                        PCWrite  = 1'b1;
                        PCSrc    = PC_ALUOUT;
                        RegWrite = 1'b1;
                        MemtoReg = WB_PC;
                        state_d  = S_IF;
                    end
                    C_JALR: begin
                        ALUSrc_A    = A_RS1;
                        ALUSrc_B    = B_IMM;
                        ALU_Control = ALU_ADD;
                        PCSrc       = PC_JALR;
                        PCWrite     = 1'b1;
                        RegWrite    = 1'b1;
                        MemtoReg    = WB_PC;
                        state_d     = S_IF;
                    end
                    C_LUI: begin
                        ALUSrc_A    = A_ZERO;
                        ALUSrc_B    = B_IMM;
                        ImmSel      = IMM_U;
                        ALU_Control = ALU_ADD;
                        state_d     = S_WB;
                    end
                    C_AUIPC: begin
                        ALUSrc_A    = A_OLDPC;
                        ALUSrc_B    = B_IMM;
                        ImmSel      = IMM_U;
                        ALU_Control = ALU_ADD;
                        state_d     = S_WB;
                    end
                    default: begin
                        // Only reachable if IR changed after ID; treat as illegal.
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
                MemRW  = (cls == C_SW);
                if (MIO_ready) begin
                    state_d = (cls == C_LW) ? S_WB : S_IF;
                end else if (wd_expire) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (cls == C_LW) ? WB_MDR : WB_ALUOUT;
                state_d  = S_IF;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Watchdog next value: cleared on every state change, counts wait cycles otherwise.
    always_comb begin
        wd_d = wd_q;
        if (state_d != state_q) begin
            wd_d = '0;
        end else if (wait_cycle) begin
            wd_d = wd_q + WDW'(1);
        end
    end

    // State, watchdog and sticky trap registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            wd_q         <= '0;
            trap_q       <= 1'b0;
            trap_cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            if (state_q != S_TRAP && state_d == S_TRAP) begin
                trap_q       <= 1'b1;
                trap_cause_q <= cause_d;
            end
        end
    end

    assign CPU_MIO    = MemReq;
    assign state      = state_q;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Bench for mcpu_ctrl: stimulus pushes the expected output vector for each
// state the FSM should enter (plus how long the previous state should have
// lasted); a monitor pops and compares on every state entry.
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       Zero;
    logic       MIO_ready;
    logic       PCWrite;
    logic [1:0] PCSrc;
    logic       IRWrite;
    logic       IorD;
    logic       MemReq;
    logic       MemRW;
    logic       CPU_MIO;
    logic [2:0] ImmSel;
    logic [1:0] ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic [3:0] ALU_Control;
    logic [1:0] MemtoReg;
    logic       RegWrite;
    logic [2:0] state;
    logic       trap;
    logic [1:0] trap_cause;

    mcpu_ctrl #(.MIO_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .OPcode(OPcode), .Fun3(Fun3), .Fun7(Fun7),
        .Zero(Zero), .MIO_ready(MIO_ready), .PCWrite(PCWrite), .PCSrc(PCSrc),
        .IRWrite(IRWrite), .IorD(IorD), .MemReq(MemReq), .MemRW(MemRW),
        .CPU_MIO(CPU_MIO), .ImmSel(ImmSel), .ALUSrc_A(ALUSrc_A),
        .ALUSrc_B(ALUSrc_B), .ALU_Control(ALU_Control), .MemtoReg(MemtoReg),
        .RegWrite(RegWrite), .state(state), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] K_AND = 4'b0000;
    localparam logic [3:0] K_ADD = 4'b0010;
    localparam logic [3:0] K_SRL = 4'b0101;
    localparam logic [3:0] K_SUB = 4'b0110;
    localparam logic [3:0] K_SLT = 4'b0111;

    typedef struct packed {
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcsrc;
        logic       irw;
        logic       iord;
        logic       mreq;
        logic       mrw;
        logic       cmio;
        logic [2:0] imm;
        logic [1:0] asrc;
        logic [1:0] bsrc;
        logic [3:0] alu;
        logic [1:0] m2r;
        logic       rw;
        logic       trp;
        logic [1:0] cause;
    } o_t;

    typedef struct {
        string tag;
        int    dwell;   // cycles the previous state should have lasted, -1 = unchecked
        o_t    o;
    } rec_t;

    rec_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic o_t o_idle();
        o_t o = '0;
        return o;
    endfunction

    function automatic o_t o_if(logic rdy);
        o_t o = '0;
        o.st = 3'd1; o.mreq = 1'b1; o.cmio = 1'b1; o.bsrc = 2'b10; o.alu = K_ADD;
        o.irw = rdy; o.pcw = rdy;
        return o;
    endfunction

    function automatic o_t o_id(logic [2:0] imm);
        o_t o = '0;
        o.st = 3'd2; o.asrc = 2'b10; o.bsrc = 2'b01; o.alu = K_ADD; o.imm = imm;
        return o;
    endfunction

    function automatic o_t o_ex(logic [1:0] a, logic [1:0] b, logic [2:0] imm, logic [3:0] alu);
        o_t o = '0;
        o.st = 3'd3; o.asrc = a; o.bsrc = b; o.imm = imm; o.alu = alu;
        return o;
    endfunction

    function automatic o_t o_mem(logic wr);
        o_t o = '0;
        o.st = 3'd4; o.mreq = 1'b1; o.cmio = 1'b1; o.iord = 1'b1; o.mrw = wr;
        return o;
    endfunction

    function automatic o_t o_wb(logic [1:0] m2r);
        o_t o = '0;
        o.st = 3'd5; o.rw = 1'b1; o.m2r = m2r;
        return o;
    endfunction

    function automatic o_t o_trap(logic [1:0] c);
        o_t o = '0;
        o.st = 3'd7; o.trp = 1'b1; o.cause = c;
        return o;
    endfunction

    task automatic push(string tag, int dwell, o_t o);
        rec_t r;
        r.tag = tag; r.dwell = dwell; r.o = o;
        sb.push_back(r);
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_ir(string tag, logic [31:0] ir);
        OPcode = ir[6:2];
        Fun3   = ir[14:12];
        Fun7   = ir[30];
        $display("[TB] issue %s ir=%08h", tag, ir);
    endtask

    // Four-state ALU-type instruction (IF, ID, EX, WB), zero-wait memory.
    task automatic alu4(string tag, logic [31:0] ir, int prev, logic [1:0] a, logic [1:0] b,
                        logic [2:0] imm_id, logic [2:0] imm_ex, logic [3:0] alu);
        push({tag, ".IF"}, prev, o_if(1'b1));
        push({tag, ".ID"}, 1, o_id(imm_id));
        push({tag, ".EX"}, 1, o_ex(a, b, imm_ex, alu));
        push({tag, ".WB"}, 1, o_wb(2'b00));
        set_ir(tag, ir);
        tick(4);
    endtask

    // Reset pulse raised mid-cycle; the IDLE entry is seen before any clock edge.
    task automatic do_reset(string tag, int prev);
        push({tag, ".IDLE"}, prev, o_idle());
        #2 rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
    endtask

    // Monitor: compare outputs on each state entry against the scoreboard.
    initial begin : monitor
        logic [2:0] last;
        int         cnt;
        o_t         got;
        rec_t       r;
        last = 3'd6;
        cnt  = 0;
        forever begin
            @(negedge clk);
            if (state !== last) begin
                got = {state, PCWrite, PCSrc, IRWrite, IorD, MemReq, MemRW, CPU_MIO, ImmSel,
                       ALUSrc_A, ALUSrc_B, ALU_Control, MemtoReg, RegWrite, trap, trap_cause};
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_entry: state %0d entered, no entry expected", state);
                end else begin
                    r = sb.pop_front();
                    n_tests++;
                    if (got !== r.o) begin
                        n_fail++;
                        $display("FAIL %s: outputs got %07h want %07h", r.tag, got, r.o);
                    end else begin
                        $display("[MON] %s state=%0d ok", r.tag, state);
                    end
                    if (r.dwell >= 0) begin
                        n_tests++;
                        if (cnt != r.dwell) begin
                            n_fail++;
                            $display("FAIL %s_dwell: previous state lasted %0d cycles, want %0d",
                                     r.tag, cnt, r.dwell);
                        end
                    end
                end
                last = state;
                cnt  = 1;
            end else begin
                cnt++;
            end
        end
    end

    // Stimulus.
    initial begin
        rst = 1'b1;
        MIO_ready = 1'b1;
        Zero = 1'b0;
        OPcode = 5'b0; Fun3 = 3'b0; Fun7 = 1'b0;
        push("reset.IDLE", -1, o_idle());
        tick(2);
        rst = 1'b0;
        tick(1);

        alu4("add",  32'h001100B3, 2, 2'b01, 2'b00, 3'b000, 3'b000, K_ADD);
        alu4("sub",  32'h400080B3, 1, 2'b01, 2'b00, 3'b000, 3'b000, K_SUB);
        alu4("srl",  32'h002150B3, 1, 2'b01, 2'b00, 3'b000, 3'b000, K_SRL);
        alu4("slti", 32'hFFF12093, 1, 2'b01, 2'b01, 3'b000, 3'b000, K_SLT);
        alu4("lui",  32'h123450B7, 1, 2'b11, 2'b01, 3'b100, 3'b100, K_ADD);

        // lw with three MEM wait cycles: 8 cycles in total.
        push("lw.IF", 1, o_if(1'b1));
        push("lw.ID", 1, o_id(3'b000));
        push("lw.EX", 1, o_ex(2'b01, 2'b01, 3'b000, K_ADD));
        push("lw.MEM", 1, o_mem(1'b0));
        push("lw.WB", 4, o_wb(2'b01));
        set_ir("lw", 32'h00812083);
        tick(3);
        MIO_ready = 1'b0;
        tick(3);
        MIO_ready = 1'b1;
        tick(2);

        // sw: MEM writes, then straight back to IF.
        push("sw.IF", 1, o_if(1'b1));
        push("sw.ID", 1, o_id(3'b001));
        push("sw.EX", 1, o_ex(2'b01, 2'b01, 3'b001, K_ADD));
        push("sw.MEM", 1, o_mem(1'b1));
        set_ir("sw", 32'h00C0A823);
        tick(4);

        // beq taken, beq not taken, bne taken.
        begin
            o_t e;
            push("beq_t.IF", 1, o_if(1'b1));
            push("beq_t.ID", 1, o_id(3'b010));
            e = o_ex(2'b01, 2'b00, 3'b000, K_SUB); e.pcsrc = 2'b01; e.pcw = 1'b1;
            push("beq_t.EX", 1, e);
            Zero = 1'b1;
            set_ir("beq_t", 32'hFE108AE3);
            tick(3);

            push("beq_n.IF", 1, o_if(1'b1));
            push("beq_n.ID", 1, o_id(3'b010));
            e = o_ex(2'b01, 2'b00, 3'b000, K_SUB); e.pcsrc = 2'b01;
            push("beq_n.EX", 1, e);
            Zero = 1'b0;
            set_ir("beq_n", 32'hFE108AE3);
            tick(3);

            push("bne_t.IF", 1, o_if(1'b1));
            push("bne_t.ID", 1, o_id(3'b010));
            e = o_ex(2'b01, 2'b00, 3'b000, K_SUB); e.pcsrc = 2'b01; e.pcw = 1'b1;
            push("bne_t.EX", 1, e);
            set_ir("bne_t", 32'hFE109AE3);
            tick(3);

            push("jal.IF", 1, o_if(1'b1));
            push("jal.ID", 1, o_id(3'b011));
            e = o_ex(2'b00, 2'b00, 3'b000, K_AND);
            e.pcw = 1'b1; e.pcsrc = 2'b01; e.rw = 1'b1; e.m2r = 2'b10;
            push("jal.EX", 1, e);
            set_ir("jal", 32'h3FE000EF);
            tick(3);

            push("jalr.IF", 1, o_if(1'b1));
            push("jalr.ID", 1, o_id(3'b000));
            e = o_ex(2'b01, 2'b01, 3'b000, K_ADD);
            e.pcw = 1'b1; e.pcsrc = 2'b10; e.rw = 1'b1; e.m2r = 2'b10;
            push("jalr.EX", 1, e);
            set_ir("jalr", 32'h000080E7);
            tick(3);
        end

        // auipc after a two-cycle fetch stall.
        push("auipc.IF", 1, o_if(1'b0));
        push("auipc.ID", 3, o_id(3'b100));
        push("auipc.EX", 1, o_ex(2'b10, 2'b01, 3'b100, K_ADD));
        push("auipc.WB", 1, o_wb(2'b00));
        MIO_ready = 1'b0;
        set_ir("auipc", 32'h00000097);
        tick(2);
        MIO_ready = 1'b1;
        tick(4);

        // and: ready arrives on the 16th fetch cycle, the watchdog limit edge.
        push("and_wd.IF", 1, o_if(1'b0));
        push("and_wd.ID", 16, o_id(3'b000));
        push("and_wd.EX", 1, o_ex(2'b01, 2'b00, 3'b000, K_AND));
        push("and_wd.WB", 1, o_wb(2'b00));
        MIO_ready = 1'b0;
        set_ir("and_wd", 32'h0020F0B3);
        tick(15);
        MIO_ready = 1'b1;
        tick(4);

        // Illegal opcode 0x7F traps from ID with cause 01; ready is ignored in TRAP.
        push("ill_op.IF", 1, o_if(1'b1));
        push("ill_op.ID", 1, o_id(3'b000));
        push("ill_op.TRAP", 1, o_trap(2'b01));
        set_ir("ill_op", 32'h0000007F);
        tick(3);
        MIO_ready = 1'b0;
        tick(1);
        MIO_ready = 1'b1;
        tick(1);
        do_reset("rst1", 3);

        // Fetch never completes: 16 wait cycles then TRAP with cause 10.
        push("timeout.IF", 3, o_if(1'b0));
        push("timeout.TRAP", 16, o_trap(2'b10));
        MIO_ready = 1'b0;
        set_ir("timeout", 32'h001100B3);
        tick(16);
        tick(3);
        MIO_ready = 1'b1;
        do_reset("rst2", 3);

        // Unsupported ALU function (sll, Fun3=001) traps from ID with cause 01.
        push("ill_f3.IF", 3, o_if(1'b1));
        push("ill_f3.ID", 1, o_id(3'b000));
        push("ill_f3.TRAP", 1, o_trap(2'b01));
        set_ir("ill_f3", 32'h002090B3);
        tick(2);
        tick(3);

        // Final reset, held so the FSM stays in IDLE.
        push("rst3.IDLE", 3, o_idle());
        #2 rst = 1'b1;
        tick(3);

        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d expected entries never seen, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
